// File: rtl/sha256_pkg.sv
// SHA-256/224 shared constants, state encoding and round helper functions.
// Working variables and H words are packed with a/H0 in the top word.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FIN
    } state_t;

    typedef logic [7:0][31:0]  wv_t;
    typedef logic [15:0][31:0] win_t;

    localparam wv_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam wv_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x,
                                         input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_rounds_rpc.sv
// Combinational block of RPC consecutive SHA-256 rounds.
// Window word 15 is W[base]; the next window is shifted by RPC words.
module sha256_rounds_rpc
    import sha256_pkg::*;
#(
    parameter int RPC = 8
) (
    input  wv_t        wv_i,
    input  win_t       win_i,
    input  logic [5:0] base_i,
    output wv_t        wv_o,
    output win_t       win_o
);

    always_comb begin
        logic [31:0] ext [16+RPC];
        logic [31:0] v [8];
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < 16; i++) ext[i] = win_i[15-i];
        // New schedule words may depend on words made earlier in this cycle.
        for (int i = 16; i < 16 + RPC; i++) begin
            ext[i] = ssig1(ext[i-2]) + ext[i-7]
                   + ssig0(ext[i-15]) + ext[i-16];
        end
        for (int k = 0; k < 8; k++) v[k] = wv_i[7-k];
        for (int j = 0; j < RPC; j++) begin
            t1 = v[7] + bsig1(v[4]) + ch(v[4], v[5], v[6])
               + K[base_i + 6'(j)] + ext[j];
            t2 = bsig0(v[0]) + maj(v[0], v[1], v[2]);
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int k = 0; k < 8; k++) wv_o[7-k] = v[k];
        for (int i = 0; i < 16; i++) win_o[15-i] = ext[i+RPC];
    end

endmodule

// File: rtl/sha256_mb_core.sv
// Multi-block SHA-256/SHA-224 core, RPC rounds per clock.
// One block in flight: IDLE -> LOAD -> RUN x (64/RPC) -> FIN.
module sha256_mb_core
    import sha256_pkg::*;
#(
    parameter int RPC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         mode_224,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sha256_mb_core: RPC must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] LAST_RND = 6'(64 - RPC);

    state_t       state_q, state_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic         first_q, first_d;
    logic         last_q, last_d;
    logic         mode_q, mode_d;
    logic         open_q, open_d;
    logic [5:0]   rnd_q, rnd_d;
    wv_t          h_q, h_d;
    wv_t          wv_q, wv_d;
    win_t         win_q, win_d;
    logic [255:0] digest_q, digest_d;
    logic         dv_q, dv_d;

    wv_t          rnd_wv;
    win_t         rnd_win;
    logic         accept;
    logic         first_eff;

    sha256_rounds_rpc #(
        .RPC (RPC)
    ) u_rounds (
        .wv_i   (wv_q),
        .win_i  (win_q),
        .base_i (rnd_q),
        .wv_o   (rnd_wv),
        .win_o  (rnd_win)
    );

    assign accept    = blk_valid & ready_q;
    // A non-first block with no open message starts one anyway.
    assign first_eff = blk_first | ~open_q;

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        last_d   = last_q;
        mode_d   = mode_q;
        open_d   = open_q;
        rnd_d    = rnd_q;
        h_d      = h_q;
        wv_d     = wv_q;
        win_d    = win_q;
        digest_d = digest_q;
        dv_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    first_d = first_eff;
                    last_d  = blk_last;
                    if (first_eff) mode_d = mode_224;
                    open_d  = 1'b1;
                    win_d   = blk_data;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (first_q) begin
                    h_d  = mode_q ? IV224 : IV256;
                    wv_d = h_d;
                end else begin
                    wv_d = h_q;
                end
                rnd_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wv_d  = rnd_wv;
                win_d = rnd_win;
                rnd_d = rnd_q + 6'(RPC);
                if (rnd_q == LAST_RND) state_d = ST_FIN;
            end
            ST_FIN: begin
                for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
                if (last_q) begin
                    digest_d = mode_q ? {h_d[7:1], 32'h0} : h_d;
                    dv_d     = 1'b1;
                    open_d   = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            mode_q   <= 1'b0;
            open_q   <= 1'b0;
            rnd_q    <= '0;
            h_q      <= '0;
            wv_q     <= '0;
            win_q    <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            first_q  <= first_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            open_q   <= open_d;
            rnd_q    <= rnd_d;
            h_q      <= h_d;
            wv_q     <= wv_d;
            win_q    <= win_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
        end
    end

    assign blk_ready    = ready_q;
    assign busy         = busy_q;
    assign digest       = digest_q;
    assign digest_valid = dv_q;

endmodule
